mem_cycle_ctrl: RTL and testbench
=================================

# mem_cycle_ctrl

Parametrised asynchronous-SRAM bus cycle controller: the successor to the single-shot read-cycle sequencer. Accepts read or write requests, issues the address latch, chip-enable, output-enable and write-enable strobes with programmable wait states, and runs bursts of up to 2^BURST_W beats by pulsing the address-counter increment between beats. Sits between the lab datapath's address counter/latch and the external SRAM pins.

## Interface
- WAIT_STATES, 1: extra ACCESS cycles per beat beyond the first (ACCESS lasts WAIT_STATES+1 cycles); legal 0..15
- BURST_W, 4: width of burst_len; beats per request = burst_len+1
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- read  in  1  read request, sampled on rising edge while idle
- write  in  1  write request, sampled on rising edge while idle
- burst_len  in  BURST_W  beats minus one, captured with the request
- latch  out  1  address-latch load pulse
- count  out  1  address-counter increment pulse
- not_ce  out  1  SRAM chip enable, active-low
- not_oe  out  1  SRAM output enable, active-low
- not_we  out  1  SRAM write enable, active-low
- reading  out  1  high while a read transaction is in progress (LATCH..last ACCESS)
- writing  out  1  high while a write transaction is in progress
- strobe  out  1  one-cycle pulse on the last ACCESS cycle of every beat (read: capture data; write: data consumed)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in RECOVER

## Operation
- States: IDLE, LATCH, ACCESS, NEXT, RECOVER. All outputs are decoded from registered state (Moore); no combinational input-to-output path.
- Reset values: state=IDLE; latch=0, count=0, not_ce=1, not_oe=1, not_we=1, reading=0, writing=0, strobe=0, busy=0, done=0; beat and wait counters 0.
- IDLE: read=1 -> LATCH with op=READ; else write=1 -> LATCH with op=WRITE; read wins if both high. burst_len captured into beat counter.
- LATCH (1 cycle): latch=1, not_ce=1, busy=1, reading/writing per op. -> ACCESS, wait counter loaded with WAIT_STATES.
- ACCESS (WAIT_STATES+1 cycles): not_ce=0; not_oe=0 for READ, not_we=0 for WRITE. Wait counter decrements; on cycle where it is 0, strobe=1 and exit: beat counter 0 -> RECOVER, else -> NEXT.
- NEXT (1 cycle): count=1, not_ce=0, not_oe=1, not_we=1 (WE rising edge between beats); beat counter decrements. -> ACCESS, wait counter reloaded.
- RECOVER (1 cycle): not_ce=1, not_oe=1, not_we=1, done=1, reading=writing=0, busy=1. -> IDLE.
- read/write while busy are ignored, not queued; a request held high through RECOVER starts a new transaction from IDLE one cycle later.
- Counter widths: beat counter BURST_W bits, no wrap (stops at 0); wait counter 4 bits.

## Timing
- Request sampled at edge k: latch high in cycle k+1, first ACCESS cycle k+2, first strobe k+2+WAIT_STATES.
- Total busy cycles per request = 2 + (burst_len+1)*(WAIT_STATES+1) + burst_len + ... RECOVER = 2 + N*(W+1) + (N-1), N=beats, W=WAIT_STATES.
- Minimum request-to-request spacing: busy cycles + 1 (IDLE cycle).
- not_oe and not_we never low in the same cycle; not_we low only while not_ce low.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously); no done pulse; transaction is dropped.

## Configuration
- MEM_CYCLE_WRITE_EN defined: write path as above.
- Undefined: write input ignored, not_we tied 1, writing tied 0; read-only controller; op register omitted.

## Structure
- Package mem_cycle_pkg: state enum (IDLE, LATCH, ACCESS, NEXT, RECOVER), op enum (READ, WRITE), MAX_WAIT_STATES=15 constant.
- One sub-module: cycle_wait_cnt (loadable 4-bit down-counter with zero flag) used for ACCESS timing.

## Test plan
- Reset then read=1 for one cycle, burst_len=0, WAIT_STATES=1 -> latch at k+1, not_ce/not_oe low k+2..k+3, strobe at k+3, done at k+4, busy 4 cycles.
- read with burst_len=3 -> 4 strobes, 3 count pulses, not_ce low continuously from first ACCESS to last ACCESS, not_oe high in each NEXT cycle.
- write with burst_len=1 (macro defined) -> not_we low 2 cycles per beat, not_oe stays 1, writing=1, one count pulse; macro undefined -> no activity, busy stays 0.
- read and write high same edge -> read transaction only; write pulses during busy -> ignored.
- reset asserted during second beat of 4-beat read -> outputs to reset values same cycle, no done; next read runs normally.
- WAIT_STATES=0, burst_len=15 -> 16 strobes on consecutive ACCESS cycles separated by single NEXT cycles, total busy 33 cycles.

Source files
------------

// File: rtl/mem_cycle_pkg.sv
// Shared types and limits for the async-SRAM bus cycle controller.
package mem_cycle_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    ACCESS  = 3'd2,
    NEXT    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_t;

  localparam int MAX_WAIT_STATES = 15;

endpackage

// File: rtl/cycle_wait_cnt.sv
// Loadable 4-bit down-counter with zero flag; holds at zero.
module cycle_wait_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_cycle_ctrl.sv
// Async-SRAM read/write burst cycle sequencer with programmable wait states.
// Define MEM_CYCLE_WRITE_EN to enable the write path; otherwise read-only.
module mem_cycle_ctrl
  import mem_cycle_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int BURST_W     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [BURST_W-1:0] burst_len,
  output logic               latch,
  output logic               count,
  output logic               not_ce,
  output logic               not_oe,
  output logic               not_we,
  output logic               reading,
  output logic               writing,
  output logic               strobe,
  output logic               busy,
  output logic               done
);

  localparam int WS = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
  localparam logic [3:0] WAIT_INIT = 4'(WS);

  state_t             state, state_nxt;
  logic [BURST_W-1:0] beat;
  logic               wait_load, wait_dec, wait_zero;
  logic               wr_req, is_write, in_txn;

`ifdef MEM_CYCLE_WRITE_EN
  op_t op;

  assign wr_req = write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op <= READ;
    end else if (state == IDLE && (read || write)) begin
      op <= read ? READ : WRITE;
    end
  end

  assign is_write = (op == WRITE);
`else
  logic unused_write;
  assign unused_write = write;
  assign wr_req       = 1'b0;
  assign is_write     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (read || wr_req)) begin
        beat <= burst_len;
      end else if (state == NEXT && beat != '0) begin
        beat <= beat - BURST_W'(1);
      end
    end
  end

  cycle_wait_cnt u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load),
    .load_val (WAIT_INIT),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

  always_comb begin
    state_nxt = state;
    wait_load = 1'b0;
    wait_dec  = 1'b0;
    case (state)
      IDLE:    if (read || wr_req) state_nxt = LATCH;
      LATCH: begin
        wait_load = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (wait_zero) state_nxt = (beat == '0) ? RECOVER : NEXT;
        else           wait_dec  = 1'b1;
      end
      NEXT: begin
        wait_load = 1'b1;
        state_nxt = ACCESS;
      end
      RECOVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore decode: every output depends only on registered state/op/counter.
  assign in_txn  = (state == LATCH) || (state == ACCESS) || (state == NEXT);
  assign latch   = (state == LATCH);
  assign count   = (state == NEXT);
  assign not_ce  = !((state == ACCESS) || (state == NEXT));
  assign not_oe  = !((state == ACCESS) && !is_write);
  assign not_we  = !((state == ACCESS) && is_write);
  assign reading = in_txn && !is_write;
  assign writing = in_txn && is_write;
  assign strobe  = (state == ACCESS) && wait_zero;
  assign busy    = (state != IDLE);
  assign done    = (state == RECOVER);

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Directed bench for mem_cycle_ctrl: WAIT_STATES=1 instance plus a WAIT_STATES=0 instance.
module tb_mem_cycle_ctrl;

  localparam int LATCH_B = 9, COUNT_B = 8, CE_B = 7, OE_B = 6, WE_B = 5;
  localparam int RD_B = 4, WR_B = 3, STB_B = 2, BUSY_B = 1, DONE_B = 0;
  localparam logic [9:0] RESET_VAL = 10'b00_111_00_0_0_0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       read1 = 1'b0, read0 = 1'b0, write = 1'b0;
  logic [3:0] bl1 = '0, bl0 = '0;
  logic [9:0] o1, o0, o;
  logic       sel = 1'b0;

  int n_tests = 0, n_fail = 0;
  int m_busy, m_strobe, m_count, m_latch, m_done, m_ce, m_oe, m_we, m_rd, m_wr, m_viol;

  always #5 clk = ~clk;

  mem_cycle_ctrl #(.WAIT_STATES(1), .BURST_W(4)) dut (
    .clk(clk), .reset(reset), .read(read1), .write(write), .burst_len(bl1),
    .latch(o1[LATCH_B]), .count(o1[COUNT_B]), .not_ce(o1[CE_B]), .not_oe(o1[OE_B]),
    .not_we(o1[WE_B]), .reading(o1[RD_B]), .writing(o1[WR_B]), .strobe(o1[STB_B]),
    .busy(o1[BUSY_B]), .done(o1[DONE_B])
  );

  mem_cycle_ctrl #(.WAIT_STATES(0), .BURST_W(4)) dut0 (
    .clk(clk), .reset(reset), .read(read0), .write(1'b0), .burst_len(bl0),
    .latch(o0[LATCH_B]), .count(o0[COUNT_B]), .not_ce(o0[CE_B]), .not_oe(o0[OE_B]),
    .not_we(o0[WE_B]), .reading(o0[RD_B]), .writing(o0[WR_B]), .strobe(o0[STB_B]),
    .busy(o0[BUSY_B]), .done(o0[DONE_B])
  );

  assign o = sel ? o0 : o1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction already requested on the inputs; optionally pulses write at cycle wr_at.
  task automatic measure(input int wr_at);
    bit finished = 1'b0;
    m_busy = 0; m_strobe = 0; m_count = 0; m_latch = 0; m_done = 0;
    m_ce = 0; m_oe = 0; m_we = 0; m_rd = 0; m_wr = 0; m_viol = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      read1 = 1'b0;
      read0 = 1'b0;
      write = (i == wr_at);
      if (!o[BUSY_B]) begin
        finished = 1'b1;
        break;
      end
      m_busy++;
      if (o[STB_B])   m_strobe++;
      if (o[COUNT_B]) m_count++;
      if (o[LATCH_B]) m_latch++;
      if (o[DONE_B])  m_done++;
      if (!o[CE_B])   m_ce++;
      if (!o[OE_B])   m_oe++;
      if (!o[WE_B])   m_we++;
      if (o[RD_B])    m_rd++;
      if (o[WR_B])    m_wr++;
      if ((!o[OE_B] && !o[WE_B]) || (!o[WE_B] && o[CE_B]) ||
          (o[COUNT_B] && (!o[OE_B] || !o[WE_B])) || (o[STB_B] && o[CE_B]))
        m_viol++;
    end
    write = 1'b0;
    if (!finished) check("txn_timeout", 1, 0);
  endtask

  initial begin
    int acc_busy, acc_we;

    // Reset values
    repeat (2) tick();
    check("rst_outs_w1", o1, RESET_VAL);
    check("rst_outs_w0", o0, RESET_VAL);
    reset = 1'b0;
    tick();
    check("post_rst_idle", o1, RESET_VAL);

    // Single read, burst_len=0, WAIT_STATES=1: cycle-by-cycle
    read1 = 1'b1; bl1 = 4'd0;
    tick();
    read1 = 1'b0;
    check("s_latch", o1, 10'b10_111_10_0_1_0);
    tick();
    check("s_acc1", o1, 10'b00_001_10_0_1_0);
    tick();
    check("s_acc2_strobe", o1, 10'b00_001_10_1_1_0);
    tick();
    check("s_recover", o1, 10'b00_111_00_0_1_1);
    tick();
    check("s_idle", o1, RESET_VAL);

    // 4-beat read, WAIT_STATES=1
    read1 = 1'b1; bl1 = 4'd3;
    measure(-1);
    check("b4_busy", m_busy, 13);
    check("b4_strobes", m_strobe, 4);
    check("b4_counts", m_count, 3);
    check("b4_latch", m_latch, 1);
    check("b4_done", m_done, 1);
    check("b4_ce_low", m_ce, 11);
    check("b4_oe_low", m_oe, 8);
    check("b4_reading", m_rd, 12);
    check("b4_viol", m_viol, 0);

    // Write burst_len=1
`ifdef MEM_CYCLE_WRITE_EN
    write = 1'b1; bl1 = 4'd1;
    measure(-1);
    check("wr_busy", m_busy, 7);
    check("wr_we_low", m_we, 4);
    check("wr_oe_low", m_oe, 0);
    check("wr_writing", m_wr, 6);
    check("wr_reading", m_rd, 0);
    check("wr_counts", m_count, 1);
    check("wr_strobes", m_strobe, 2);
    check("wr_viol", m_viol, 0);
`else
    write = 1'b1; bl1 = 4'd1;
    acc_busy = 0; acc_we = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o1[BUSY_B]) acc_busy++;
      if (!o1[WE_B] || o1[WR_B]) acc_we++;
    end
    write = 1'b0;
    check("ro_wr_busy", acc_busy, 0);
    check("ro_wr_we", acc_we, 0);
`endif

    // Read and write on the same edge: read wins
    tick();
    read1 = 1'b1; write = 1'b1; bl1 = 4'd1;
    measure(-1);
    check("rw_busy", m_busy, 7);
    check("rw_reading", m_rd, 6);
    check("rw_writing", m_wr, 0);
    check("rw_we_low", m_we, 0);
    check("rw_oe_low", m_oe, 4);

    // Write pulse during a busy read is dropped, not queued
    read1 = 1'b1; bl1 = 4'd0;
    measure(1);
    check("ign_busy", m_busy, 4);
    check("ign_writing", m_wr, 0);
    tick();
    check("ign_no_queue", o1[BUSY_B], 0);

    // Reset during second beat of a 4-beat read
    read1 = 1'b1; bl1 = 4'd3;
    tick();
    read1 = 1'b0;
    repeat (4) tick();
    check("mid_second_beat", o1, 10'b00_001_10_0_1_0);
    #2 reset = 1'b1;
    #1 check("mid_rst_async", o1, RESET_VAL);
    tick();
    check("mid_rst_no_done", o1[DONE_B], 0);
    reset = 1'b0;
    tick();
    check("mid_rst_idle", o1, RESET_VAL);
    read1 = 1'b1; bl1 = 4'd0;
    measure(-1);
    check("after_rst_busy", m_busy, 4);
    check("after_rst_strobe", m_strobe, 1);
    check("after_rst_done", m_done, 1);

    // WAIT_STATES=0, 16 beats
    sel = 1'b1;
    read0 = 1'b1; bl0 = 4'd15;
    measure(-1);
    check("w0_busy", m_busy, 33);
    check("w0_strobes", m_strobe, 16);
    check("w0_counts", m_count, 15);
    check("w0_ce_low", m_ce, 31);
    check("w0_oe_low", m_oe, 16);
    check("w0_done", m_done, 1);
    check("w0_viol", m_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
